// File: rtl/uart_alu_ctrl.sv
// Sequencer between uart_rx, a combinational ALU and uart_tx.
// Collects A, B, opcode; launches the result; flags timeouts and overruns.
module uart_alu_ctrl #(
  parameter int NB_DATA     = 8,
  parameter int NB_OP       = 6,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx_done_tick,
  input  logic [NB_DATA-1:0] rx_data,
  input  logic [NB_DATA-1:0] alu_result,
  input  logic               tx_done_tick,
  output logic [NB_DATA-1:0] alu_a,
  output logic [NB_DATA-1:0] alu_b,
  output logic [NB_OP-1:0]   alu_op,
  output logic [NB_DATA-1:0] tx_data,
  output logic               tx_start,
  output logic               busy,
  output logic               err_timeout,
  output logic               err_overrun
);

  localparam int CW =
    (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : '0;
  localparam logic TO_EN = (TIMEOUT_CYC > 0);

  typedef enum logic [2:0] {
    WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX
  } state_t;

  state_t             state_q, state_d;
  logic [NB_DATA-1:0] a_q, a_d, b_q, b_d, tx_q, tx_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               err_to_q, err_to_d;
  logic               err_ov_q, err_ov_d;
  logic               busy_s, expired;

  assign busy_s = (state_q == EXEC) || (state_q == SEND) ||
                  (state_q == WAIT_TX);
  assign expired = TO_EN && (cnt_q == CNT_LAST);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    tx_d     = tx_q;
    cnt_d    = '0;
    err_to_d = 1'b0;
    err_ov_d = busy_s && rx_done_tick;
    unique case (state_q)
      WAIT_A: if (rx_done_tick) begin
        a_d     = rx_data;
        state_d = WAIT_B;
      end
      WAIT_B, WAIT_OP: begin
        if (rx_done_tick) begin
          if (state_q == WAIT_B) begin
            b_d     = rx_data;
            state_d = WAIT_OP;
          end else begin
            op_d    = rx_data[NB_OP-1:0];
            state_d = EXEC;
          end
        end else if (expired) begin
          err_to_d = 1'b1;
          state_d  = WAIT_A;
        end else if (TO_EN) begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        end
      end
      EXEC: begin
        tx_d    = alu_result;
        state_d = SEND;
      end
      SEND: state_d = WAIT_TX;
      WAIT_TX: if (tx_done_tick) state_d = WAIT_A;
      default: state_d = WAIT_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= WAIT_A;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      tx_q     <= '0;
      cnt_q    <= '0;
      err_to_q <= 1'b0;
      err_ov_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      tx_q     <= tx_d;
      cnt_q    <= cnt_d;
      err_to_q <= err_to_d;
      err_ov_q <= err_ov_d;
    end
  end

  // Strobes come straight off the state register, no input path.
  assign tx_start    = (state_q == SEND);
  assign busy        = busy_s;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_op      = op_q;
  assign tx_data     = tx_q;
  assign err_timeout = err_to_q;
  assign err_overrun = err_ov_q;

endmodule
